// File: rtl/instr_encoder.sv
// instr_encoder
//   Accepts decoded instruction fields one at a time, encodes each into a
//   32-bit MIPS-style word and writes it into an instruction memory at
//   consecutive word addresses starting from a session base address.
//
// Handshake rules:
//   A field transfer happens on a rising edge where in_valid and in_ready are
//   both high. in_ready is only high in ACCEPT. A memory write completes on a
//   rising edge where imem_we and imem_ack are both high; imem_we holds with
//   stable address/data until that edge.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 one-cycle session request (honoured only in IDLE)
//   base_addr, count      first word address and number of instructions
//   in_valid / in_ready   instruction-field handshake
//   in_op                 mnemonic 0..9 (ADD SUB AND OR SLT LW SW BEQ ADDI J)
//   in_rs/rt/rd/imm/target instruction fields
//   imem_we/addr/wdata    instruction-memory write port
//   imem_ack              memory accepts the write this cycle
//   busy, done, err       status: in session, end-of-session pulse, sticky abort
//   words_written         words written in the current/last session
//   dbg_state             current FSM state for observation
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_written,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ZERO = '0;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;

    logic              op_legal;
    logic [31:0]       enc_word;

    // Opcodes 10..15 have no encoding and abort the session.
    assign op_legal = (in_op <= 4'd9);

    always_comb begin
        enc_word = 32'h0000_0000;
        case (in_op)
            4'd0: enc_word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h20}; // ADD
            4'd1: enc_word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h22}; // SUB
            4'd2: enc_word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h24}; // AND
            4'd3: enc_word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h25}; // OR
            4'd4: enc_word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h2A}; // SLT
            4'd5: enc_word = {6'h23, in_rs, in_rt, in_imm};             // LW
            4'd6: enc_word = {6'h2B, in_rs, in_rt, in_imm};             // SW
            4'd7: enc_word = {6'h04, in_rs, in_rt, in_imm};             // BEQ
            4'd8: enc_word = {6'h08, in_rs, in_rt, in_imm};             // ADDI
            4'd9: enc_word = {6'h02, in_target};                        // J
            default: enc_word = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            words_q     <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            words_q     <= words_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        words_d     = words_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    words_d = '0;
                    if (count != CNT_ZERO) begin
                        addr_d      = base_addr;
                        remaining_d = count;
                        state_d     = S_ACCEPT;
                    end else begin
                        // Empty session: report completion without writing.
                        state_d = S_DONE;
                    end
                end
            end
            S_ACCEPT: begin
                if (in_valid) begin
                    if (op_legal) begin
                        wdata_d = enc_word;
                        state_d = S_WRITE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                if (imem_ack) begin
                    words_d     = words_q + CNT_ONE;
                    addr_d      = addr_q + ADDR_ONE; // wraps modulo 2^ADDR_W
                    remaining_d = remaining_q - CNT_ONE;
                    state_d     = (remaining_q == CNT_ONE) ? S_DONE : S_ACCEPT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready      = (state_q == S_ACCEPT);
    assign imem_we       = (state_q == S_WRITE);
    assign imem_addr     = addr_q;
    assign imem_wdata    = wdata_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;
    assign words_written = words_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int ADDR_W = 6;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rs, in_rt, in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ack;
    logic              busy, done, err;
    logic [ADDR_W:0]   words_written;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .count         (count),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_rs         (in_rs),
        .in_rt         (in_rt),
        .in_rd         (in_rd),
        .in_imm        (in_imm),
        .in_target     (in_target),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .imem_ack      (imem_ack),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .words_written (words_written),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
        start     = 1'b1;
        base_addr = b;
        count     = c;
        tick();
        start     = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        int k;
        in_op     = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_imm    = imm;
        in_target = tgt;
        in_valid  = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Called right after a legal transfer: checks the held write for
    // 1+stall cycles, acknowledging in the last one.
    task automatic write_ack(input string tag, input logic [ADDR_W-1:0] ea,
                             input logic [31:0] ed, input int stall);
        for (int i = 0; i <= stall; i++) begin
            check({tag, "_we"},    32'(imem_we),    32'd1);
            check({tag, "_addr"},  32'(imem_addr),  32'(ea));
            check({tag, "_data"},  imem_wdata,      ed);
            check({tag, "_ready"}, 32'(in_ready),   32'd0);
            if (i == stall) imem_ack = 1'b1;
            tick();
            imem_ack = 1'b0;
        end
        check({tag, "_we_off"}, 32'(imem_we), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; count = '0;
        in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_imm = '0; in_target = '0; imem_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_we",    32'(imem_we),       32'd0);
        check("rst_ready", 32'(in_ready),      32'd0);
        check("rst_busy",  32'(busy),          32'd0);
        check("rst_done",  32'(done),          32'd0);
        check("rst_err",   32'(err),           32'd0);
        check("rst_words", 32'(words_written), 32'd0);

        // Single ADD at base 4
        do_start(6'd4, 7'd1);
        check("t1_busy",  32'(busy),     32'd1);
        check("t1_ready", 32'(in_ready), 32'd1);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        write_ack("t1", 6'd4, 32'h0022_1820, 0);
        check("t1_done",  32'(done),          32'd1);
        check("t1_busy2", 32'(busy),          32'd1);
        check("t1_words", 32'(words_written), 32'd1);
        tick();
        check("t1_done_off", 32'(done), 32'd0);
        check("t1_idle",     32'(busy), 32'd0);

        // LW, BEQ, J at consecutive addresses
        do_start(6'd10, 7'd3);
        send(4'd5, 5'd0, 5'd8, 5'd0, 16'h0004, 26'h0);
        write_ack("t2_lw", 6'd10, 32'h8C08_0004, 0);
        check("t2_nodone1", 32'(done), 32'd0);
        send(4'd7, 5'd8, 5'd9, 5'd0, 16'hFFFF, 26'h0);
        write_ack("t2_beq", 6'd11, 32'h1109_FFFF, 0);
        send(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0010);
        write_ack("t2_j", 6'd12, 32'h0800_0010, 0);
        check("t2_done",  32'(done),          32'd1);
        check("t2_words", 32'(words_written), 32'd3);
        tick();

        // ADDI with ack held low for 5 cycles
        do_start(6'd20, 7'd1);
        send(4'd8, 5'd3, 5'd4, 5'd0, 16'h1234, 26'h0);
        write_ack("t3", 6'd20, 32'h2064_1234, 5);
        check("t3_done", 32'(done), 32'd1);
        tick();

        // Illegal op after one good write: abort, sticky err
        do_start(6'd0, 7'd2);
        send(4'd2, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
        write_ack("t4_and", 6'd0, 32'h0021_0824, 0);
        send(4'd12, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
        check("t4_err",   32'(err),           32'd1);
        check("t4_we",    32'(imem_we),       32'd0);
        check("t4_busy",  32'(busy),          32'd0);
        check("t4_done",  32'(done),          32'd0);
        check("t4_words", 32'(words_written), 32'd1);
        tick();
        check("t4_done2", 32'(done), 32'd0);
        check("t4_err2",  32'(err),  32'd1);
        do_start(6'd5, 7'd1);
        check("t4_err_clr", 32'(err), 32'd0);
        send(4'd1, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0);
        write_ack("t4_sub", 6'd5, 32'h00A6_3822, 0);
        check("t4_done3", 32'(done), 32'd1);
        tick();

        // Address wrap 63 -> 0
        do_start(6'd63, 7'd2);
        send(4'd3, 5'd0, 5'd0, 5'd2, 16'h0, 26'h0);
        write_ack("t5_or", 6'd63, 32'h0000_1025, 0);
        send(4'd4, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0);
        write_ack("t5_slt", 6'd0, 32'h0043_202A, 0);
        check("t5_done",  32'(done),          32'd1);
        check("t5_err",   32'(err),           32'd0);
        check("t5_words", 32'(words_written), 32'd2);
        tick();

        // Empty session
        do_start(6'd9, 7'd0);
        check("t6_done",  32'(done),          32'd1);
        check("t6_busy",  32'(busy),          32'd1);
        check("t6_we",    32'(imem_we),       32'd0);
        check("t6_words", 32'(words_written), 32'd0);
        tick();
        check("t6_done_off", 32'(done),    32'd0);
        check("t6_we2",      32'(imem_we), 32'd0);

        // Reset in the middle of a write
        do_start(6'd7, 7'd1);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        check("t7_we_pre", 32'(imem_we), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t7_we",    32'(imem_we),       32'd0);
        check("t7_addr",  32'(imem_addr),     32'd0);
        check("t7_data",  imem_wdata,         32'd0);
        check("t7_ready", 32'(in_ready),      32'd0);
        check("t7_busy",  32'(busy),          32'd0);
        check("t7_done",  32'(done),          32'd0);
        check("t7_err",   32'(err),           32'd0);
        check("t7_words", 32'(words_written), 32'd0);
        tick();
        check("t7_nodone", 32'(done), 32'd0);

        // Start and ack ignored while in ACCEPT
        do_start(6'd2, 7'd2);
        start = 1'b1; base_addr = 6'd30; count = 7'd1; imem_ack = 1'b1;
        tick();
        start = 1'b0; imem_ack = 1'b0;
        check("t8_ready", 32'(in_ready),      32'd1);
        check("t8_words", 32'(words_written), 32'd0);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        write_ack("t8_w0", 6'd2, 32'h0022_1820, 0);
        check("t8_nodone", 32'(done),     32'd0);
        check("t8_ready2", 32'(in_ready), 32'd1);
        send(4'd6, 5'd4, 5'd5, 5'd0, 16'h0008, 26'h0);
        write_ack("t8_sw", 6'd3, 32'hAC85_0008, 0);
        check("t8_done",  32'(done),          32'd1);
        check("t8_words2", 32'(words_written), 32'd2);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, giving the instruction-memory word-address width.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a load session.
REQ-005 SHALL have port base_addr  input  ADDR_W  first word address of the session.
REQ-006 SHALL have port count  input  ADDR_W+1  number of instructions in the session.
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1) as the instruction-field handshake.
REQ-008 SHALL have port in_op  input  4  mnemonic: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 ADDI, 9 J; 10-15 are illegal.
REQ-009 SHALL have ports in_rs, in_rt, in_rd (input, 5 each), in_imm (input, 16) and in_target (input, 26) as the instruction fields.
REQ-010 SHALL have ports imem_we (output, 1), imem_addr (output, ADDR_W) and imem_wdata (output, 32) as the instruction-memory write port.
REQ-011 SHALL have port imem_ack  input  1  memory accepts the write in the current cycle.
REQ-012 SHALL have outputs busy (1), done (1, pulse), err (1, sticky) and words_written (ADDR_W+1).

Function
REQ-013 SHALL encode R-type operations as {6'h00, rs, rt, rd, 5'b0, funct}, with funct 0x20 for ADD, 0x22 for SUB, 0x24 for AND, 0x25 for OR and 0x2A for SLT.
REQ-014 SHALL encode I-type operations as {opcode, rs, rt, imm}, with opcode 0x23 for LW, 0x2B for SW, 0x04 for BEQ and 0x08 for ADDI.
REQ-015 SHALL encode J as {6'h02, target}.
REQ-016 SHALL implement the FSM states IDLE, ACCEPT, WRITE and DONE.
REQ-017 SHALL, in IDLE, drive busy=0 and in_ready=0; start with count!=0 SHALL load addr=base_addr and remaining=count, clear err and words_written, and go to ACCEPT.
REQ-018 SHALL, in IDLE, treat start with count==0 as follows: clear err and words_written, go to DONE, and perform no write.
REQ-019 SHALL, in ACCEPT, drive in_ready=1 and busy=1; a transfer occurs only when in_valid and in_ready are both high in the same cycle.
REQ-020 SHALL, on a legal op transfer, register the encoded word into imem_wdata and go to WRITE, so that imem_we is high in the cycle after the transfer.
REQ-021 SHALL, on an illegal op transfer, set err, perform no write, leave words_written unchanged, and go to IDLE (session abort, no done pulse).
REQ-022 SHALL, in WRITE, hold imem_we=1 with imem_addr and imem_wdata stable and drive in_ready=0 until imem_ack.
REQ-023 SHALL treat imem_ack as completing the write in the same cycle that imem_we is high, and on that cycle increment words_written, increment addr modulo 2^ADDR_W, and decrement remaining.
REQ-024 SHALL, on the ack cycle, go to DONE if remaining was 1 and otherwise go to ACCEPT; imem_we SHALL be 0 in the following cycle.
REQ-025 SHALL, in DONE, drive done=1 and busy=1 for exactly one cycle, then go to IDLE.
REQ-026 SHALL ignore start in every state except IDLE.
REQ-027 SHALL ignore imem_ack outside WRITE.
REQ-028 SHALL allow at most one word per 2 cycles (ACCEPT then WRITE with immediate ack).
REQ-029 SHALL wrap imem_addr from 2^ADDR_W-1 to 0 with no error.
REQ-030 SHALL hold err from the abort until the next accepted start or reset.

Reset
REQ-031 SHALL, on reset high at a clock edge, enter IDLE and drive imem_we, imem_addr, imem_wdata, in_ready, busy, done, err and words_written to 0, in every state including mid-WRITE.
REQ-032 SHALL produce no write and no done pulse for any session interrupted by reset.

Verification
REQ-033 SHALL verify: start, base=4, count=1, ADD rs=1 rt=2 rd=3 with ack at first we -> imem_wdata=0x00221820, imem_addr=4, done one cycle later, words_written=1.
REQ-034 SHALL verify: count=3 sending LW rs=0 rt=8 imm=0x0004, BEQ rs=8 rt=9 imm=0xFFFF, J target=0x0000010 -> writes 0x8C080004, 0x1109FFFF, 0x08000010 at consecutive addresses.
REQ-035 SHALL verify: ack held low 5 cycles -> imem_we, imem_addr and imem_wdata stable for 6 cycles, in_ready=0 throughout.
REQ-036 SHALL verify: in_op=12 in ACCEPT -> err=1, no imem_we, busy=0 next cycle, no done; the next start clears err.
REQ-037 SHALL verify: base=63, count=2 (ADDR_W=6) -> writes at 63 then 0; start with count=0 -> done pulse, no write.
REQ-038 SHALL verify: reset asserted during WRITE -> all outputs 0 next cycle; start during ACCEPT is ignored.
